// File: rtl/timing_seq_decoder.sv
// timing_seq_decoder
// Step counter driving an enabled one-hot decoder. Produces the T0..Tn step
// strobes that sequence fetch/decode/execute in the multi-cycle control unit.
//
// Optional feature macro: TSEQ_ERR_EN (adds the sticky ERR illegal-load flag).
//
// Parameters:
//   SEL_W      step-counter width; the decoder has 2**SEL_W outputs
//   LAST_STEP  highest step reached by counting (<= 2**SEL_W-1)
// Ports:
//   CLK       clock, all state on rising edge
//   RST       synchronous active-high reset
//   EN        advance one step per cycle
//   CLR       synchronous clear of the step counter
//   LOAD      synchronous load of LOAD_VAL
//   LOAD_VAL  step value for LOAD
//   OUT_EN    decoder enable; 0 forces all T low
//   SC        registered step count
//   T         one-hot step strobes
//   WRAP      an EN increment from LAST_STEP is pending this cycle
//   ERR       sticky illegal-load flag (TSEQ_ERR_EN only)
module timing_seq_decoder #(
    parameter int unsigned SEL_W     = 3,
    parameter int unsigned LAST_STEP = 2**SEL_W - 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic                    CLR,
    input  logic                    LOAD,
    input  logic [SEL_W-1:0]        LOAD_VAL,
    input  logic                    OUT_EN,
    output logic [SEL_W-1:0]        SC,
    output logic [(2**SEL_W)-1:0]   T,
    output logic                    WRAP
`ifdef TSEQ_ERR_EN
    ,
    output logic                    ERR
`endif
);

    localparam int unsigned NUM_T = 2**SEL_W;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(LAST_STEP);

    logic [SEL_W-1:0] sc_q, sc_d;
    logic             load_legal;
    logic             at_last;

    // When LAST_STEP is the counter maximum every load value is legal; the
    // split keeps the comparison from degenerating into a constant.
    if (LAST_STEP >= NUM_T - 1) begin : g_full_range
        assign load_legal = 1'b1;
    end else begin : g_part_range
        assign load_legal = (LOAD_VAL <= LAST);
    end

    assign at_last = (sc_q == LAST);

    always_comb begin
        sc_d = sc_q;
        if (CLR) begin
            sc_d = '0;
        end else if (LOAD) begin
            if (load_legal) begin
                sc_d = LOAD_VAL;
            end else begin
`ifdef TSEQ_ERR_EN
                sc_d = sc_q;  // illegal load ignored; EN also suppressed
`else
                sc_d = '0;
`endif
            end
        end else if (EN) begin
            // Values above LAST only arise from parameter misuse; they wrap
            // naturally modulo 2**SEL_W.
            sc_d = at_last ? '0 : sc_q + SEL_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sc_q <= '0;
        end else begin
            sc_q <= sc_d;
        end
    end

`ifdef TSEQ_ERR_EN
    logic err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (!CLR && LOAD && !load_legal) begin
            err_q <= 1'b1;
        end
    end

    assign ERR = err_q;
`endif

    assign SC   = sc_q;
    assign T    = OUT_EN ? (NUM_T'(1) << sc_q) : '0;
    assign WRAP = EN & ~CLR & ~LOAD & ~RST & at_last;

endmodule

// File: tb/tb_timing_seq_decoder.sv
module tb_timing_seq_decoder;

    logic       clk = 1'b0;
    logic       rst, en, clr, load, out_en;
    logic [3:0] lv;

    logic [2:0]  sc7, sc4;
    logic [3:0]  sc16;
    logic [7:0]  t7, t4;
    logic [15:0] t16;
    logic        wr7, wr4, wr16;
    logic        err7, err4, err16;

    int checks   = 0;
    int failures = 0;

    localparam int D7 = 0, D4 = 1, D16 = 2;

    always #5 clk = ~clk;

    timing_seq_decoder #(.SEL_W(3), .LAST_STEP(7)) u_d7 (
        .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .LOAD(load), .LOAD_VAL(lv[2:0]),
        .OUT_EN(out_en), .SC(sc7), .T(t7), .WRAP(wr7)
`ifdef TSEQ_ERR_EN
        , .ERR(err7)
`endif
    );

    timing_seq_decoder #(.SEL_W(3), .LAST_STEP(4)) u_d4 (
        .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .LOAD(load), .LOAD_VAL(lv[2:0]),
        .OUT_EN(out_en), .SC(sc4), .T(t4), .WRAP(wr4)
`ifdef TSEQ_ERR_EN
        , .ERR(err4)
`endif
    );

    timing_seq_decoder #(.SEL_W(4), .LAST_STEP(15)) u_d16 (
        .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .LOAD(load), .LOAD_VAL(lv),
        .OUT_EN(out_en), .SC(sc16), .T(t16), .WRAP(wr16)
`ifdef TSEQ_ERR_EN
        , .ERR(err16)
`endif
    );

`ifndef TSEQ_ERR_EN
    assign err7  = 1'b0;
    assign err4  = 1'b0;
    assign err16 = 1'b0;
`endif

    typedef struct {
        int          id;
        string       nm;
        logic [3:0]  sc;
        logic [15:0] t;
        logic        wr;
        logic        err;
    } exp_t;

    exp_t q[$];

    function automatic logic [15:0] oh(input int sc, input logic oe);
        logic [15:0] one;
        one = 16'd1;
        return oe ? (one << sc) : 16'd0;
    endfunction

    function automatic void push(input int id, input string nm, input int sc,
                                 input logic [15:0] t, input logic wr, input logic err);
        exp_t e;
        e.id = id; e.nm = nm; e.sc = 4'(sc); e.t = t; e.wr = wr; e.err = err;
        q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0;
        tick();
        push(D7,  "rst_d7",  0, oh(0, out_en), 1'b0, 1'b0);
        push(D4,  "rst_d4",  0, oh(0, out_en), 1'b0, 1'b0);
        push(D16, "rst_d16", 0, oh(0, out_en), 1'b0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    // Monitor: the counter presents a new step every cycle, so every queued
    // expectation is compared at the falling edge following its issue.
    initial begin
        exp_t        e;
        logic [3:0]  a_sc;
        logic [15:0] a_t;
        logic        a_wr, a_err, ok;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.id)
                    D7:      begin a_sc = {1'b0, sc7}; a_t = {8'h0, t7}; a_wr = wr7; a_err = err7; end
                    D4:      begin a_sc = {1'b0, sc4}; a_t = {8'h0, t4}; a_wr = wr4; a_err = err4; end
                    default: begin a_sc = sc16; a_t = t16; a_wr = wr16; a_err = err16; end
                endcase
                ok = (a_sc === e.sc) && (a_t === e.t) && (a_wr === e.wr);
`ifdef TSEQ_ERR_EN
                ok = ok && (a_err === e.err);
`endif
                checks++;
                if (!ok) begin
                    failures++;
                    $display("FAIL %s: got sc=%0d t=%h wrap=%b err=%b, want sc=%0d t=%h wrap=%b err=%b",
                             e.nm, a_sc, a_t, a_wr, a_err, e.sc, e.t, e.wr, e.err);
                end
            end
        end
    end

    initial begin
        int s;
        rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; lv = 4'd0; out_en = 1'b1;

        // Free-running count on all three configurations.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(D7,  "cnt_d7",  i % 8, oh(i % 8, 1'b1), (i % 8) == 7, 1'b0);
            push(D4,  "cnt_d4",  i % 5, oh(i % 5, 1'b1), (i % 5) == 4, 1'b0);
            push(D16, "cnt_d16", i,     oh(i, 1'b1),     1'b0,         1'b0);
            tick();
        end

        // Masked outputs: counter keeps running, WRAP unaffected.
        out_en = 1'b0;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(D7, "mask_d7", i, 16'h0000, i == 7, 1'b0);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            out_en = (i == 5);
            push(D7, "oe_d7", i, (i == 5) ? 16'h0020 : 16'h0000, 1'b0, 1'b0);
            tick();
        end

        // Control priority on the LAST_STEP=7 instance.
        out_en = 1'b1;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(D7, "pre_d7", i, oh(i, 1'b1), 1'b0, 1'b0);
            tick();
        end
        load = 1'b1; lv = 4'd6;
        push(D7, "ld_en_d7", 3, 16'h0008, 1'b0, 1'b0);
        tick();
        clr = 1'b1; lv = 4'd2; en = 1'b0;
        push(D7, "after_ld_d7", 6, 16'h0040, 1'b0, 1'b0);
        tick();
        clr = 1'b0; load = 1'b0; en = 1'b1;
        push(D7, "after_clr_d7", 0, 16'h0001, 1'b0, 1'b0);
        tick();
        push(D7, "cnt1_d7", 1, 16'h0002, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        push(D7, "rst_en_d7", 2, 16'h0004, 1'b0, 1'b0);
        tick();
        rst = 1'b0; en = 1'b0;
        push(D7, "after_rst_d7", 0, 16'h0001, 1'b0, 1'b0);
        tick();
        push(D7, "hold_d7", 0, 16'h0001, 1'b0, 1'b0);
        tick();

        // Illegal load on the LAST_STEP=4 instance.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push(D4, "pre_d4", i, oh(i, 1'b1), 1'b0, 1'b0);
            tick();
        end
        load = 1'b1; lv = 4'd6;
        push(D4, "ill_ld_d4", 2, 16'h0004, 1'b0, 1'b0);
        tick();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
`ifdef TSEQ_ERR_EN
            s = (2 + k) % 5;
            push(D4, "post_ill_d4", s, oh(s, 1'b1), s == 4, 1'b1);
`else
            s = k;
            push(D4, "post_ill_d4", s, oh(s, 1'b1), 1'b0, 1'b0);
`endif
            tick();
        end
`ifdef TSEQ_ERR_EN
        s = 1;
`else
        s = 4;
`endif
        rst = 1'b1;
        push(D4, "ill_rst_d4", s, oh(s, 1'b1), 1'b0, 1'b1);
        tick();
        rst = 1'b0; en = 1'b0;
        push(D4, "err_clr_d4", 0, 16'h0001, 1'b0, 1'b0);
        tick();

        // 16-step wrap on the SEL_W=4 instance.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(D16, "wrap_d16", i, oh(i, 1'b1), i == 15, 1'b0);
            tick();
        end
        en = 1'b0;
        push(D16, "back0_d16", 0, 16'h0001, 1'b0, 1'b0);
        tick();

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d pending, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
